// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: bundles the scan driver's data inputs and display-pin
// outputs so the formatting logic and the pin driver connect with one port.
//
// Signals:
//   seg_in      7*NUM_DIGITS  segment pattern per digit, digit k at [7k+6:7k]
//   dp_in       NUM_DIGITS    decimal point per digit, already in pin polarity
//   digit_en    NUM_DIGITS    1 = digit displayed, 0 = slot kept but dark
//   brightness  4             duty level 0..15
//   blink_mask  NUM_DIGITS    digits that blink (only with SEG_SCAN_BLINK_EN)
//   an          NUM_DIGITS    anode select, one-hot asserted or all inactive
//   sseg        7             shared segment bus
//   dp          1             shared decimal point
//   frame_tick  1             one-cycle pulse per completed scan
//
// Modports: master = producer of the patterns (drives inputs, sees pins),
//           slave  = the scan driver itself.
// Optional feature macro: SEG_SCAN_BLINK_EN adds blink_mask.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [7*NUM_DIGITS-1:0] seg_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              brightness;
`ifdef SEG_SCAN_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              sseg;
  logic                    dp;
  logic                    frame_tick;

`ifdef SEG_SCAN_BLINK_EN
  modport master (
    output seg_in, dp_in, digit_en, brightness, blink_mask,
    input  an, sseg, dp, frame_tick
  );
  modport slave (
    input  seg_in, dp_in, digit_en, brightness, blink_mask,
    output an, sseg, dp, frame_tick
  );
`else
  modport master (
    output seg_in, dp_in, digit_en, brightness,
    input  an, sseg, dp, frame_tick
  );
  modport slave (
    input  seg_in, dp_in, digit_en, brightness,
    output an, sseg, dp, frame_tick
  );
`endif
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment scan driver.
// Each digit owns a slot of REFRESH_DIV clocks. The first GUARD_CYCLES of a
// slot are blanked to stop ghosting from the previous digit; the lit part of
// the slot is further shortened by a 16-level brightness duty. The digit's
// pattern, dp and enable are captured at slot start so mid-slot changes on
// the inputs never tear the displayed digit.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    seg_scan_mux_if.slave (seg_in, dp_in, digit_en, brightness in;
//          an, sseg, dp, frame_tick out)
//
// Optional feature macro: SEG_SCAN_BLINK_EN adds parameter BLINK_FRAMES and
// the interface input blink_mask; blinking digits are dark every other
// BLINK_FRAMES frames.
module seg_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int GUARD_CYCLES   = 2,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 32
`endif
) (
  input logic           clk,
  input logic           reset,
  seg_scan_mux_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Wide enough for 16*REFRESH_DIV, so the duty product never overflows.
  localparam int ON_W  = CNT_W + 5;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [ON_W-1:0]       GUARD    = ON_W'(GUARD_CYCLES);
  localparam logic [ON_W-1:0]       DIV      = ON_W'(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_start;
  logic             slot_end;
  logic             frame_end;

  assign slot_start = (cnt == '0);
  assign slot_end   = (cnt == CNT_LAST);
  assign frame_end  = slot_end && (idx == IDX_LAST);

  // ---- stage p0: slot timing (cnt within slot, idx = digit being scanned)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  logic [6:0] live_seg;
  logic       live_dp;
  logic       live_en;

  assign live_seg = bus.seg_in[7*idx +: 7];
  assign live_dp  = bus.dp_in[idx];

`ifdef SEG_SCAN_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [BF_W-1:0] frame_cnt;
  logic            blink_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == BF_LAST) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + BF_W'(1);
      end
    end
  end

  // A blinking digit in its off phase is captured exactly as if disabled.
  assign live_en = bus.digit_en[idx] & ~(blink_off & bus.blink_mask[idx]);
`else
  assign live_en = bus.digit_en[idx];
`endif

  // ---- stage p0: slot capture (pattern, dp, enable per slot; brightness per frame)
  logic [6:0] cap_seg;
  logic       cap_dp;
  logic       cap_en;
  logic [3:0] bright_lat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_seg    <= SEG_OFF;
      cap_dp     <= DP_OFF;
      cap_en     <= 1'b0;
      bright_lat <= 4'hF;
    end else if (slot_start) begin
      cap_seg <= live_seg;
      cap_dp  <= live_dp;
      cap_en  <= live_en;
      if (idx == '0) begin
        bright_lat <= bus.brightness;
      end
    end
  end

  // The capture registers only become valid one clock into the slot, so the
  // cnt==0 cycle reads the live inputs that are being captured in it. This
  // keeps GUARD_CYCLES=0 correct without an extra pipeline stage.
  logic [6:0]            cur_seg;
  logic                  cur_dp;
  logic                  cur_en;
  logic [3:0]            cur_bright;
  logic [ON_W-1:0]       on_prod;
  logic [ON_W-1:0]       on_time;
  logic [ON_W-1:0]       cnt_w;
  logic                  active;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] an_sel;

  assign cur_seg    = slot_start ? live_seg : cap_seg;
  assign cur_dp     = slot_start ? live_dp  : cap_dp;
  assign cur_en     = slot_start ? live_en  : cap_en;
  assign cur_bright = (slot_start && (idx == '0)) ? bus.brightness : bright_lat;

  assign on_prod = (ON_W'(cur_bright) + ON_W'(1)) * DIV;
  assign on_time = on_prod >> 4;
  assign cnt_w   = ON_W'(cnt);

  // on_time <= GUARD leaves this empty: digit simply stays dark.
  assign active  = (cnt_w >= GUARD) && (cnt_w < on_time) && cur_en;

  assign onehot  = NUM_DIGITS'(1) << idx;
  assign an_sel  = AN_ACTIVE_LOW ? ~onehot : onehot;

  // ---- stage p1: registered pin drive
  logic [NUM_DIGITS-1:0] an_p1;
  logic [6:0]            sseg_p1;
  logic                  dp_p1;
  logic                  ft_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_p1   <= AN_OFF;
      sseg_p1 <= SEG_OFF;
      dp_p1   <= DP_OFF;
      ft_p1   <= 1'b0;
    end else begin
      if (active) begin
        an_p1   <= an_sel;
        sseg_p1 <= cur_seg;
        dp_p1   <= cur_dp;
      end else begin
        an_p1   <= AN_OFF;
        sseg_p1 <= SEG_OFF;
        dp_p1   <= DP_OFF;
      end
      ft_p1 <= frame_end;
    end
  end

  assign bus.an         = an_p1;
  assign bus.sseg       = sseg_p1;
  assign bus.dp         = dp_p1;
  assign bus.frame_tick = ft_p1;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int G  = 1;
  localparam int FR = RD * ND;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus();

  seg_scan_mux #(
    .NUM_DIGITS    (ND),
    .REFRESH_DIV   (RD),
    .GUARD_CYCLES  (G),
    .AN_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: position on the timeline t (clocks since reset release)
  // gives slot cnt = t mod RD and digit = (t / RD) mod ND directly.
  int unsigned t;
  logic [6:0]  m_seg [ND];
  logic        m_dp  [ND];
  logic        m_en  [ND];
  logic [3:0]  m_bri;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_ft;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t     <= 0;
      e_an  <= 4'hF;
      e_seg <= 7'h7F;
      e_dp  <= 1'b1;
      e_ft  <= 1'b0;
      m_bri <= 4'hF;
      for (int i = 0; i < ND; i++) begin
        m_seg[i] <= 7'h7F;
        m_dp[i]  <= 1'b1;
        m_en[i]  <= 1'b0;
      end
    end else begin
      automatic int         c  = int'(t % RD);
      automatic int         d  = int'((t / RD) % ND);
      automatic logic [6:0] s  = (c == 0) ? bus.seg_in[7*d +: 7] : m_seg[d];
      automatic logic       p  = (c == 0) ? bus.dp_in[d] : m_dp[d];
      automatic logic       en = (c == 0) ? bus.digit_en[d] : m_en[d];
      automatic int         b  = (c == 0 && d == 0) ? int'(bus.brightness) : int'(m_bri);
      automatic int         on = ((b + 1) * RD) / 16;
      automatic bit         lit = (c >= G) && (c < on) && en;
      e_an  <= lit ? ~(4'b0001 << d) : 4'hF;
      e_seg <= lit ? s : 7'h7F;
      e_dp  <= lit ? p : 1'b1;
      e_ft  <= (c == RD - 1) && (d == ND - 1);
      if (c == 0) begin
        m_seg[d] <= s;
        m_dp[d]  <= p;
        m_en[d]  <= en;
        if (d == 0) m_bri <= 4'(b);
      end
      t <= t + 1;
    end
  end

  // Per-cycle compare plus running totals for window measurements.
  bit chk_en = 1'b0;
  int act_tot [ND] = '{default: 0};
  int tick_tot = 0;
  int dpl_tot  = 0;
  int dplo_tot = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("an", bus.an, e_an);
      chk("sseg", bus.sseg, e_seg);
      chk("dp", bus.dp, e_dp);
      chk("frame_tick", bus.frame_tick, e_ft);
      chk("an_onehot", ($countones(~bus.an) <= 1), 1);
    end
    for (int d = 0; d < ND; d++)
      if (bus.an == ~(4'b0001 << d)) act_tot[d] <= act_tot[d] + 1;
    if (bus.frame_tick) tick_tot <= tick_tot + 1;
    if (bus.dp == 1'b0) begin
      if (bus.an == 4'b1011) dpl_tot <= dpl_tot + 1;
      else                   dplo_tot <= dplo_tot + 1;
    end
  end

  int w_act [ND];
  int w_tick, w_dpl, w_dplo;

  // Any FR consecutive cycles cover every slot phase exactly once.
  task automatic measure();
    int a0 [ND];
    int t0, d0, o0;
    a0 = act_tot;
    t0 = tick_tot;
    d0 = dpl_tot;
    o0 = dplo_tot;
    repeat (FR) @(negedge clk);
    for (int i = 0; i < ND; i++) w_act[i] = act_tot[i] - a0[i];
    w_tick = tick_tot - t0;
    w_dpl  = dpl_tot - d0;
    w_dplo = dplo_tot - o0;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((int'(t % FR) != p) && (n < 200));
    if (n >= 200) chk("wait_bound", 0, 1);
  endtask

  task automatic set_defaults();
    bus.seg_in     = {7'h30, 7'h24, 7'h79, 7'h40};
    bus.dp_in      = 4'hF;
    bus.digit_en   = 4'hF;
    bus.brightness = 4'hF;
  endtask

`ifdef SEG_SCAN_BLINK_EN
  initial bus.blink_mask = '0;
`endif

  initial begin
    set_defaults();
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", bus.an, 4'hF);
    chk("rst_sseg", bus.sseg, 7'h7F);
    chk("rst_dp", bus.dp, 1'b1);
    chk("rst_ft", bus.frame_tick, 1'b0);
    chk_en = 1'b1;
    reset  = 1'b0;

    // First slot: cnt 0 is guard, digit 0 lights on cnt 1.
    @(negedge clk);
    chk("first_guard_an", bus.an, 4'hF);
    @(negedge clk);
    chk("first_lit_an", bus.an, 4'b1110);
    chk("first_lit_sseg", bus.sseg, 7'h40);

    wait_phase(26);
    chk("d3_an", bus.an, 4'b0111);
    chk("d3_sseg", bus.sseg, 7'h30);

    // Full brightness: 7 lit cycles per slot, one tick per frame.
    measure();
    for (int i = 0; i < ND; i++) chk("full_lit_cycles", w_act[i], 7);
    chk("full_ticks", w_tick, 1);

    bus.brightness = 4'd7;
    repeat (40) @(negedge clk);
    measure();
    for (int i = 0; i < ND; i++) chk("b7_lit_cycles", w_act[i], 3);
    chk("b7_ticks", w_tick, 1);

    bus.brightness = 4'd0;
    repeat (40) @(negedge clk);
    measure();
    for (int i = 0; i < ND; i++) chk("b0_lit_cycles", w_act[i], 0);
    chk("b0_ticks", w_tick, 1);
    bus.brightness = 4'hF;

    bus.digit_en = 4'b1011;
    repeat (40) @(negedge clk);
    measure();
    chk("en_d2_dark", w_act[2], 0);
    chk("en_d0_lit", w_act[0], 7);
    chk("en_d3_lit", w_act[3], 7);
    chk("en_ticks", w_tick, 1);
    bus.digit_en = 4'hF;
    repeat (40) @(negedge clk);

    // Mid-slot change of digit 1 at cnt 4 must not tear the current slot.
    wait_phase(12);
    bus.seg_in[13:7] = 7'h12;
    wait_phase(15);
    chk("tear_same_slot_an", bus.an, 4'b1101);
    chk("tear_same_slot_sseg", bus.sseg, 7'h79);
    wait_phase(15);
    chk("tear_next_slot_sseg", bus.sseg, 7'h12);

    bus.dp_in = 4'b1011;
    repeat (40) @(negedge clk);
    measure();
    chk("dp_low_d2", w_dpl, 7);
    chk("dp_low_other", w_dplo, 0);

    // Randomized traffic against the model.
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)  bus.seg_in     = 28'($urandom);
      if ($urandom_range(0, 7) == 0)  bus.dp_in      = 4'($urandom);
      if ($urandom_range(0, 7) == 0)  bus.digit_en   = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.brightness = 4'($urandom);
    end

    // Asynchronous reset in the middle of digit 2's slot.
    set_defaults();
    repeat (40) @(negedge clk);
    wait_phase(19);
    chk("pre_reset_an", bus.an, 4'b1011);
    chk("pre_reset_sseg", bus.sseg, 7'h24);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_an", bus.an, 4'hF);
    chk("async_rst_sseg", bus.sseg, 7'h7F);
    chk("async_rst_dp", bus.dp, 1'b1);
    chk("async_rst_ft", bus.frame_tick, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_guard_an", bus.an, 4'hF);
    @(negedge clk);
    chk("restart_an", bus.an, 4'b1110);
    chk("restart_sseg", bus.sseg, 7'h40);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
